// File: rtl/mips_mem_arbiter.sv
// Arbitrates the multicycle MIPS core's instruction-fetch and load/store paths
// onto one Avalon-style memory master port, with round-robin tie-breaking.
module mips_mem_arbiter #(
  parameter int WAIT_TIMEOUT = 0,
  parameter int CNT_WIDTH    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        busy,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);

  typedef enum logic [1:0] {IDLE, BUS, ACK} state_t;

  localparam bit TIMEOUT_EN = (WAIT_TIMEOUT != 0);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST =
    CNT_WIDTH'(TIMEOUT_EN ? WAIT_TIMEOUT - 1 : 0);

  state_t state, state_n;

  // last_d: previous grant went to data; owner_d: the transfer in flight is a data access
  logic                 last_d, last_d_n;
  logic                 owner_d, owner_d_n;
  logic                 pick_d;
  logic [CNT_WIDTH-1:0] stall_cnt, stall_cnt_n;

  logic [31:0] address_n, writedata_n, i_rdata_n, d_rdata_n;
  logic        read_n, write_n, i_ack_n, d_ack_n, err_n;
  logic [3:0]  byteenable_n;

  always_comb begin
    state_n      = state;
    last_d_n     = last_d;
    owner_d_n    = owner_d;
    pick_d       = 1'b0;
    stall_cnt_n  = stall_cnt;
    address_n    = address;
    read_n       = read;
    write_n      = write;
    writedata_n  = writedata;
    byteenable_n = byteenable;
    i_rdata_n    = i_rdata;
    d_rdata_n    = d_rdata;
    i_ack_n      = 1'b0;
    d_ack_n      = 1'b0;
    err_n        = 1'b0;

    case (state)
      IDLE: begin
        stall_cnt_n = '0;
        if (!halt && (i_req || d_req)) begin
          // on a tie the requester that did not win last time goes first
          pick_d    = d_req && (!i_req || !last_d);
          state_n   = BUS;
          last_d_n  = pick_d;
          owner_d_n = pick_d;
          if (pick_d) begin
            address_n    = d_addr;
            read_n       = ~d_write;
            write_n      = d_write;
            writedata_n  = d_wdata;
            byteenable_n = d_byteenable;
          end else begin
            address_n    = i_addr;
            read_n       = 1'b1;
            write_n      = 1'b0;
            writedata_n  = '0;
            byteenable_n = 4'b1111;
          end
        end
      end

      BUS: begin
        if (!waitrequest) begin
          read_n      = 1'b0;
          write_n     = 1'b0;
          stall_cnt_n = '0;
          state_n     = ACK;
          if (owner_d) begin
            d_ack_n = 1'b1;
            if (!write) d_rdata_n = readdata;
          end else begin
            i_ack_n   = 1'b1;
            i_rdata_n = readdata;
          end
        end else if (TIMEOUT_EN && stall_cnt == TIMEOUT_LAST) begin
          read_n      = 1'b0;
          write_n     = 1'b0;
          stall_cnt_n = '0;
          state_n     = ACK;
          err_n       = 1'b1;
          if (owner_d) begin
            d_ack_n   = 1'b1;
            d_rdata_n = '0;
          end else begin
            i_ack_n   = 1'b1;
            i_rdata_n = '0;
          end
        end else begin
          stall_cnt_n = stall_cnt + CNT_WIDTH'(1);
        end
      end

      ACK: state_n = IDLE;

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_d     <= 1'b1;
      owner_d    <= 1'b0;
      stall_cnt  <= '0;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      err        <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      state      <= state_n;
      last_d     <= last_d_n;
      owner_d    <= owner_d_n;
      stall_cnt  <= stall_cnt_n;
      address    <= address_n;
      read       <= read_n;
      write      <= write_n;
      writedata  <= writedata_n;
      byteenable <= byteenable_n;
      i_ack      <= i_ack_n;
      d_ack      <= d_ack_n;
      err        <= err_n;
      i_rdata    <= i_rdata_n;
      d_rdata    <= d_rdata_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Scoreboard bench for mips_mem_arbiter: expected transfers are queued as requests
// are raised and checked against the memory strobes and the ack pulses.
`timescale 1ns/1ps
module tb_mips_mem_arbiter;

  localparam int TIMEOUT = 5;

  typedef struct {
    bit          is_data;
    bit          is_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    bit          err;
    int          start_cyc;
    int          strobes;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halt = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_byteenable = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        err;
  logic        busy;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        waitrequest;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc = 0;
  int   wait_cfg = 0;
  int   tb_stall = 0;
  int   strobe_cnt = 0;
  int   last_strobe_cyc = 0;
  bit   prev_ack = 1'b0;
  logic [31:0] d_hold = '0;
  txn_t exp_q[$];
  txn_t mon_e;

  mips_mem_arbiter #(.WAIT_TIMEOUT(TIMEOUT), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteenable(d_byteenable), .d_ack(d_ack), .d_rdata(d_rdata),
    .err(err), .busy(busy),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h2402_0005;
    return a ^ 32'h9E37_79B9;
  endfunction

  // memory stalls each access for wait_cfg cycles; readdata is junk unless accepted
  assign waitrequest = (read || write) && (tb_stall < wait_cfg);
  assign readdata    = (read && !waitrequest) ? memRead(address) : 32'hFFFF_FFFF;

  always @(posedge clk) begin
    if ((read || write) && waitrequest) tb_stall <= tb_stall + 1;
    else tb_stall <= 0;
  end

  task automatic checkOutput(input string tag, input logic [159:0] act, input logic [159:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic txn_t mkTxn(input bit is_data, input bit is_write, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 input int waits, input int start);
    txn_t t;
    t.is_data   = is_data;
    t.is_write  = is_data && is_write;
    t.addr      = addr;
    t.wdata     = is_data ? wdata : 32'h0;
    t.be        = is_data ? be : 4'b1111;
    t.rdata     = memRead(addr);
    t.err       = 1'b0;
    t.start_cyc = start;
    t.strobes   = waits + 1;
    if (waits >= TIMEOUT) begin
      t.err     = 1'b1;
      t.rdata   = 32'h0;
      t.strobes = TIMEOUT;
    end
    return t;
  endfunction

  task automatic waitAck(input bit want_d);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = want_d ? d_ack : i_ack;
    end
    if (!seen) checkOutput("ack_timeout", 0, 1);
  endtask

  task automatic applyStimulus(input bit is_data, input bit is_write, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be, input int waits);
    @(negedge clk);
    wait_cfg = waits;
    exp_q.push_back(mkTxn(is_data, is_write, addr, wdata, be, waits, cyc + 1));
    if (is_data) begin
      d_addr = addr; d_write = is_write; d_wdata = wdata; d_byteenable = be; d_req = 1'b1;
    end else begin
      i_addr = addr; i_req = 1'b1;
    end
    waitAck(is_data);
    if (is_data) d_req = 1'b0;
    else i_req = 1'b0;
  endtask

  // bus and ack monitor: every strobe cycle and every ack is matched to the queue head
  always @(negedge clk) begin
    if (!rst) begin
      if (read || write) begin
        if (exp_q.size() == 0) checkOutput("unexpected_strobe", 1, 0);
        else begin
          mon_e = exp_q[0];
          if (strobe_cnt == 0 && mon_e.start_cyc >= 0)
            checkOutput("grant_latency", cyc, mon_e.start_cyc);
          checkOutput("bus", {address, read, write, writedata, byteenable},
                      {mon_e.addr, ~mon_e.is_write, mon_e.is_write, mon_e.wdata, mon_e.be});
          strobe_cnt++;
          last_strobe_cyc = cyc;
        end
      end
      if (i_ack || d_ack) begin
        if (exp_q.size() == 0) checkOutput("unexpected_ack", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          checkOutput("ack_kind", {i_ack, d_ack, err}, {~mon_e.is_data, mon_e.is_data, mon_e.err});
          checkOutput("ack_after_strobe", cyc - last_strobe_cyc, 1);
          checkOutput("strobe_cycles", strobe_cnt, mon_e.strobes);
          checkOutput("ack_pulse", prev_ack, 0);
          checkOutput("ack_busy", busy, 1);
          if (!mon_e.is_data) checkOutput("i_rdata", i_rdata, mon_e.rdata);
          else if (mon_e.is_write) checkOutput("d_rdata_hold", d_rdata, d_hold);
          else begin
            checkOutput("d_rdata", d_rdata, mon_e.rdata);
            d_hold = mon_e.rdata;
          end
          strobe_cnt = 0;
        end
      end
      prev_ack = i_ack || d_ack;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d of %0d checks failed",
             tests_failed, tests_run);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("reset_outs",
                {read, write, address, writedata, byteenable, i_ack, d_ack, err, i_rdata, d_rdata, busy},
                160'h0);
    rst = 1'b0;

    applyStimulus(0, 0, 32'hBFC0_0000, 32'h0, 4'h0, 0);
    applyStimulus(1, 0, 32'h0000_2000, 32'h0, 4'b1111, 1);
    applyStimulus(1, 1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011, 3);

    // reset in the middle of a stalled fetch: strobe drops, no ack follows
    @(negedge clk);
    wait_cfg = 1000;
    exp_q.push_back(mkTxn(0, 0, 32'h0000_0400, 32'h0, 4'h0, 0, cyc + 1));
    i_addr = 32'h0000_0400;
    i_req  = 1'b1;
    repeat (2) @(negedge clk);
    rst   = 1'b1;
    i_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    strobe_cnt = 0;
    d_hold = 32'h0;
    checkOutput("rst_abort", {read, write, i_ack, d_ack, busy}, 0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_no_ack", {read, write, i_ack, d_ack, busy}, 0);
    end

    // both requesters re-raise right after their ack: grants must alternate I,D,I,D
    wait_cfg = 1;
    exp_q.push_back(mkTxn(0, 0, 32'h0000_0100, 32'h0, 4'h0, 1, -1));
    exp_q.push_back(mkTxn(1, 0, 32'h0000_3000, 32'h0, 4'b1111, 1, -1));
    exp_q.push_back(mkTxn(0, 0, 32'h0000_0104, 32'h0, 4'h0, 1, -1));
    exp_q.push_back(mkTxn(1, 0, 32'h0000_3004, 32'h0, 4'b1111, 1, -1));
    fork
      begin
        for (int j = 0; j < 2; j++) begin
          @(negedge clk);
          i_addr = 32'h0000_0100 + 32'(j * 4);
          i_req  = 1'b1;
          waitAck(0);
          i_req = 1'b0;
        end
      end
      begin
        for (int j = 0; j < 2; j++) begin
          @(negedge clk);
          d_addr = 32'h0000_3000 + 32'(j * 4);
          d_write = 1'b0;
          d_wdata = 32'h0;
          d_byteenable = 4'b1111;
          d_req = 1'b1;
          waitAck(1);
          d_req = 1'b0;
        end
      end
    join

    applyStimulus(1, 0, 32'h0000_4000, 32'h0, 4'b1111, 0);
    applyStimulus(1, 0, 32'h0000_4004, 32'h0, 4'b0110, 0);

    // halt raised while a load is stalled on the bus
    @(negedge clk);
    wait_cfg = 2;
    exp_q.push_back(mkTxn(1, 0, 32'h0000_5000, 32'h0, 4'b1111, 2, cyc + 1));
    d_addr = 32'h0000_5000; d_write = 1'b0; d_wdata = 32'h0; d_byteenable = 4'b1111;
    d_req = 1'b1;
    @(negedge clk);
    halt = 1'b1;
    waitAck(1);
    d_req = 1'b0;
    i_addr = 32'h0000_0200;
    i_req  = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("halt_hold", {read, write, busy}, 0);
    end
    wait_cfg = 0;
    halt = 1'b0;
    exp_q.push_back(mkTxn(0, 0, 32'h0000_0200, 32'h0, 4'h0, 0, cyc + 1));
    waitAck(0);
    i_req = 1'b0;

    applyStimulus(0, 0, 32'h0000_0300, 32'h0, 4'h0, 1000);
    @(negedge clk);
    checkOutput("timeout_idle", {busy, read, i_ack, err}, 0);

    repeat (2) @(negedge clk);
    checkOutput("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Shares the CPU's single Avalon-style memory master port between two requesters: the instruction-fetch path and the load/store data path of the multicycle MIPS core.
- Grants one requester at a time, with round-robin resolution of ties.
- Holds the bus request stable across waitrequest stalls, returns read data with a one-cycle ack pulse, and stops issuing new grants once the CPU halts.
- Sits between mips_state_machine/datapath and the external memory interface.

Parameters:
WAIT_TIMEOUT, 0, number of consecutive waitrequest-high cycles after which the transfer is aborted with err; 0 disables the timeout.
CNT_WIDTH, 8, width of the stall counter; WAIT_TIMEOUT must be < 2**CNT_WIDTH.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
halt  input  1  CPU halted; no new grants while high
i_req  input  1  instruction fetch request (read only)
i_addr  input  32  fetch byte address
i_ack  output  1  one-cycle pulse: fetch complete
i_rdata  output  32  fetch data, valid while i_ack=1
d_req  input  1  data access request
d_write  input  1  1=store, 0=load
d_addr  input  32  data byte address
d_wdata  input  32  store data
d_byteenable  input  4  store/load byte lanes
d_ack  output  1  one-cycle pulse: data access complete
d_rdata  output  32  load data, valid while d_ack=1
err  output  1  high together with i_ack/d_ack when the transfer timed out
busy  output  1  high in any state other than IDLE
address  output  32  memory address
read  output  1  memory read strobe
write  output  1  memory write strobe
writedata  output  32  memory write data
byteenable  output  4  memory byte lanes
readdata  input  32  memory read data, valid in a cycle with read=1 and waitrequest=0
waitrequest  input  1  memory stall

Behaviour:
- FSM states:
  - IDLE: no grant.
  - BUS: transfer on memory port.
  - ACK: one-cycle completion pulse.
- All outputs are registered.
- Reset: synchronous. At the next edge with rst=1:
  - state=IDLE; read=write=0; address=writedata=0; byteenable=0.
  - i_ack=d_ack=err=0; i_rdata=d_rdata=0.
  - stall counter=0; last_grant=DATA, so the first tie after reset goes to instruction.
- rst mid-transfer abandons the transfer: strobes drop at that edge and no ack is issued.
- rst takes priority over every other input.
- IDLE:
  - Requests are sampled only in IDLE, and only when halt=0.
  - Exactly one requester high: grant it.
  - Both high: grant the one that is not last_grant.
  - On the granting edge: state=BUS, last_grant updated, memory outputs loaded.
  - Instruction grant loads: address=i_addr, read=1, write=0, byteenable=4'b1111, writedata=0.
  - Data grant loads: address=d_addr, read=~d_write, write=d_write, writedata=d_wdata, byteenable=d_byteenable.
  - Latency: req high in cycle N -> strobe high in cycle N+1.
- BUS:
  - Outputs are held constant while waitrequest=1.
  - Transfer completes in the first cycle with waitrequest=0. At that edge:
    - read=write=0; readdata is captured into i_rdata or d_rdata (loads and fetches only).
    - state=ACK with the matching ack high.
  - Zero-wait memory: strobe is high for exactly one cycle; ack appears in cycle N+2.
  - Stall counter increments on each waitrequest=1 cycle in BUS and clears on leaving BUS.
  - If WAIT_TIMEOUT!=0 and the counter reaches WAIT_TIMEOUT: strobes drop, state=ACK, ack=1, err=1, rdata=0.
- ACK:
  - The ack is high for exactly one cycle; err is high only on timeout.
  - Next state is IDLE unconditionally.
  - The requester must drop req at the edge where it sees ack, so a request is never serviced twice.
  - d_rdata is not updated for stores; it holds its previous value.
- halt:
  - Asserted during BUS or ACK: the in-flight transfer completes normally.
  - While high, IDLE stays IDLE and busy=0.
  - Deasserting halt resumes arbitration next cycle.
- Starvation bound: with both requesters continuously requesting, grants strictly alternate I,D,I,D.
- A requester never waits more than one other transfer.
- Address alignment is not checked; address passes through unchanged.

Test Plan:
- Reset: drive rst=1 for 1 cycle during a stalled read -> next cycle state IDLE, read=0, no i_ack/d_ack pulse, busy=0.
- Zero-wait fetch: i_req=1, i_addr=0xBFC00000, waitrequest=0, readdata=0x24020005 -> read=1 with address=0xBFC00000 in cycle N+1 only; i_ack=1 with i_rdata=0x24020005 in cycle N+2.
- Stalled store: d_req=1, d_write=1, d_addr=0x1000, d_wdata=0xDEADBEEF, d_byteenable=4'b0011, waitrequest=1 for 3 cycles -> write, address, writedata and byteenable constant for 4 cycles; d_ack one cycle later; err=0.
- Arbitration: after reset, i_req=d_req=1 held and each dropped/re-raised after its ack -> grant order I,D,I,D; with only d_req re-raised, consecutive D grants are allowed.
- Halt: halt=1 while a load is in BUS with 2 stall cycles -> d_ack still pulses; a subsequent i_req is not granted (read stays 0, busy=0) until halt=0, then read=1 the next cycle.
- Timeout: WAIT_TIMEOUT=5, waitrequest held 1 -> strobe drops after 5 stall cycles; i_ack=1 with err=1 and i_rdata=0; then returns to IDLE.
